// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the RPN stack calculator.
//   oper_t       one-hot key codes on the op input (4'h0 = no key)
//   ARITH_*      arithmetic codes carried on payload with an ARITH_OP key
//   state_t      calculator control states
//   stk_cmd_t    datapath commands from the control FSM to calc_stack
//   err_flags_t  the four sticky error flags
// ---------------------------------------------------------------------------
package calc_pkg;

    typedef enum logic [3:0] {
        KEY_NONE = 4'h0,
        START    = 4'h1,
        ENTER    = 4'h2,
        ARITH_OP = 4'h4,
        DONE     = 4'h8
    } oper_t;

    localparam int unsigned ARITH_ADD  = 1;
    localparam int unsigned ARITH_SUB  = 2;
    localparam int unsigned ARITH_AND  = 4;
    localparam int unsigned ARITH_SWAP = 8;
    localparam int unsigned ARITH_DROP = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        STK_NONE        = 3'd0,
        STK_LOAD        = 3'd1,  // clear stack, top = data, depth = 1
        STK_PUSH        = 3'd2,  // shift down, top = data, depth + 1
        STK_POP         = 3'd3,  // shift up, depth - 1
        STK_POP_REPLACE = 3'd4,  // shift up, then top = data, depth - 1
        STK_SWAP        = 3'd5   // exchange entries 0 and 1
    } stk_cmd_t;

    typedef struct packed {
        logic stack_ovf;
        logic data_ovf;
        logic protocol_err;
        logic unexpected_done;
    } err_flags_t;

    // A key is legal only when exactly one bit is set.
    function automatic logic is_one_hot4(input logic [3:0] v);
        return (v != 4'h0) && ((v & (v - 4'h1)) == 4'h0);
    endfunction

endpackage

// File: rtl/calc_stack.sv
// ---------------------------------------------------------------------------
// calc_stack
// Operand stack datapath. Entry 0 is the top of stack. Entries at or below
// the current depth always read as zero, so the image can be exported as-is.
// The controller guarantees commands are legal for the current depth
// (no push when full, no pop below one entry).
// Ports:
//   clock, reset_N  clock and asynchronous active-low reset
//   cmd_i           datapath command (stk_cmd_t)
//   data_i          value written to the top for LOAD/PUSH/POP_REPLACE
//   stack_o         full stack image, index 0 = top
//   depth_o         number of valid entries
// ---------------------------------------------------------------------------
module calc_stack
    import calc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int DW   = $clog2(DEPTH + 1)
) (
    input  logic                         clock,
    input  logic                         reset_N,
    input  stk_cmd_t                     cmd_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic [DEPTH-1:0][WIDTH-1:0]  stack_o,
    output logic [DW-1:0]                depth_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stack_q, stack_d;
    logic [DW-1:0]               depth_q, depth_d;

    always_comb begin
        // NOTE: every variable gets a hold value before the case so that
        // commands which leave it untouched do not infer a latch.
        stack_d = stack_q;
        depth_d = depth_q;
        unique case (cmd_i)
            STK_LOAD: begin
                stack_d    = '0;
                stack_d[0] = data_i;
                depth_d    = DW'(1);
            end
            STK_PUSH: begin
                for (int i = 1; i < DEPTH; i++) begin
                    stack_d[i] = stack_q[i-1];
                end
                stack_d[0] = data_i;
                depth_d    = depth_q + 1'b1;
            end
            STK_POP: begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    stack_d[i] = stack_q[i+1];
                end
                stack_d[DEPTH-1] = '0;
                depth_d          = depth_q - 1'b1;
            end
            STK_POP_REPLACE: begin
                // Binary op: S1 and S0 are consumed, the result becomes top.
                for (int i = 0; i < DEPTH - 1; i++) begin
                    stack_d[i] = stack_q[i+1];
                end
                stack_d[DEPTH-1] = '0;
                stack_d[0]       = data_i;
                depth_d          = depth_q - 1'b1;
            end
            STK_SWAP: begin
                stack_d[0] = stack_q[1];
                stack_d[1] = stack_q[0];
            end
            default: begin
            end
        endcase
    end

    // NOTE: the stack array is reset along with depth because its full image
    // is a visible output; an unreset register file would expose stale data.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            stack_q <= '0;
            depth_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            stack_q <= stack_d;
            depth_q <= depth_d;
        end
    end

    assign stack_o = stack_q;
    assign depth_o = depth_q;

endmodule

// File: rtl/rpn_stack_calc.sv
// ---------------------------------------------------------------------------
// rpn_stack_calc
// Keyed RPN calculator: one key per clock drives a WIDTH-bit, DEPTH-entry
// operand stack. Errors are sticky until the next START or reset.
// Ports:
//   clock, reset_N     clock and asynchronous active-low reset
//   op                 one-hot key (START/ENTER/ARITH_OP/DONE), 0 = idle
//   payload            operand (START/ENTER) or arithmetic code (ARITH_OP)
//   result             top of stack captured at DONE, valid while finished
//   stackOut           stack image, index 0 = top, unused entries 0
//   depth              number of valid stack entries
//   stackOverflow      ENTER attempted on a full stack
//   dataOverflow       unsigned ADD carry or SUB borrow
//   protocolError      illegal key, sequence or arithmetic code
//   unexpectedDone     DONE from IDLE or with depth != 1
//   finished           transaction ended
//   correct            transaction ended cleanly
// ---------------------------------------------------------------------------
module rpn_stack_calc
    import calc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset_N,
    input  logic [3:0]                    op,
    input  logic [WIDTH-1:0]              payload,
    output logic [WIDTH-1:0]              result,
    output logic [DEPTH-1:0][WIDTH-1:0]   stackOut,
    output logic [$clog2(DEPTH+1)-1:0]    depth,
    output logic                          stackOverflow,
    output logic                          dataOverflow,
    output logic                          protocolError,
    output logic                          unexpectedDone,
    output logic                          finished,
    output logic                          correct
);

    localparam int DW = $clog2(DEPTH + 1);
    // Codes are compared at >= 32 bits so a narrow payload cannot alias
    // a code it is too small to carry (e.g. DROP=16 at WIDTH=4).
    localparam int CW = (WIDTH > 32) ? WIDTH : 32;

    state_t           state_q, state_d;
    err_flags_t       flags_q, flags_d;
    logic             fin_q, fin_d;
    logic             cor_q, cor_d;
    logic [WIDTH-1:0] res_q, res_d;

    stk_cmd_t                    stk_cmd;
    logic [WIDTH-1:0]            stk_data;
    logic [DEPTH-1:0][WIDTH-1:0] stk_img;
    logic [DW-1:0]               stk_depth;

    calc_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clock   (clock),
        .reset_N (reset_N),
        .cmd_i   (stk_cmd),
        .data_i  (stk_data),
        .stack_o (stk_img),
        .depth_o (stk_depth)
    );

    // ---------------- arithmetic on the two top entries ----------------
    logic [WIDTH-1:0] s0, s1;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [CW-1:0]    code_ext;
    logic             code_add, code_sub, code_and, code_swap, code_drop;
    logic             code_ok;
    logic             two_operands;

    assign s0      = stk_img[0];
    assign s1      = stk_img[1];
    assign sum_ext = {1'b0, s1} + {1'b0, s0};
    assign diff    = s1 - s0;
    assign borrow  = (s1 < s0);

    assign code_ext  = CW'(payload);
    assign code_add  = (code_ext == CW'(ARITH_ADD));
    assign code_sub  = (code_ext == CW'(ARITH_SUB));
    assign code_and  = (code_ext == CW'(ARITH_AND));
    assign code_swap = (code_ext == CW'(ARITH_SWAP));
    assign code_drop = (code_ext == CW'(ARITH_DROP));
    assign code_ok   = code_add | code_sub | code_and | code_swap | code_drop;

    assign two_operands = (stk_depth >= DW'(2));

    // ---------------- control FSM and flag logic ----------------
    always_comb begin
        state_d  = state_q;
        flags_d  = flags_q;
        fin_d    = fin_q;
        cor_d    = cor_q;
        res_d    = res_q;
        stk_cmd  = STK_NONE;
        stk_data = payload;

        if (op != 4'h0) begin
            if (!is_one_hot4(op)) begin
                // A completed transaction ignores everything but START.
                if (state_q != ST_FIN) begin
                    flags_d.protocol_err = 1'b1;
                    state_d              = ST_ERR;
                end
            end else begin
                unique case (state_q)
                    ST_IDLE, ST_FIN: begin
                        if (op == START) begin
                            flags_d = '0;
                            fin_d   = 1'b0;
                            cor_d   = 1'b0;
                            res_d   = '0;
                            stk_cmd = STK_LOAD;
                            state_d = ST_RUN;
                        end else if (state_q == ST_IDLE) begin
                            if (op == DONE) begin
                                flags_d.unexpected_done = 1'b1;
                                fin_d                   = 1'b1;
                                cor_d                   = 1'b0;
                                state_d                 = ST_FIN;
                            end else begin
                                flags_d.protocol_err = 1'b1;
                                state_d              = ST_ERR;
                            end
                        end
                    end

                    ST_RUN: begin
                        unique case (op)
                            ENTER: begin
                                if (stk_depth == DW'(DEPTH)) begin
                                    flags_d.stack_ovf = 1'b1;
                                    state_d           = ST_ERR;
                                end else begin
                                    stk_cmd = STK_PUSH;
                                end
                            end
                            ARITH_OP: begin
                                if (!code_ok || !two_operands) begin
                                    flags_d.protocol_err = 1'b1;
                                    state_d              = ST_ERR;
                                end else if (code_add) begin
                                    stk_cmd  = STK_POP_REPLACE;
                                    stk_data = sum_ext[WIDTH-1:0];
                                    if (sum_ext[WIDTH]) begin
                                        flags_d.data_ovf = 1'b1;
                                        state_d          = ST_ERR;
                                    end
                                end else if (code_sub) begin
                                    stk_cmd  = STK_POP_REPLACE;
                                    stk_data = diff;
                                    if (borrow) begin
                                        flags_d.data_ovf = 1'b1;
                                        state_d          = ST_ERR;
                                    end
                                end else if (code_and) begin
                                    stk_cmd  = STK_POP_REPLACE;
                                    stk_data = s1 & s0;
                                end else if (code_swap) begin
                                    stk_cmd = STK_SWAP;
                                end else begin
                                    stk_cmd = STK_POP;
                                end
                            end
                            DONE: begin
                                fin_d   = 1'b1;
                                res_d   = s0;
                                state_d = ST_FIN;
                                if (stk_depth == DW'(1)) begin
                                    cor_d = 1'b1;
                                end else begin
                                    cor_d                   = 1'b0;
                                    flags_d.unexpected_done = 1'b1;
                                end
                            end
                            default: begin
                                // START while a transaction is open.
                                flags_d.protocol_err = 1'b1;
                                state_d              = ST_ERR;
                            end
                        endcase
                    end

                    ST_ERR: begin
                        if (op == DONE) begin
                            fin_d   = 1'b1;
                            cor_d   = 1'b0;
                            res_d   = s0;
                            state_d = ST_FIN;
                        end
                    end

                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state_q <= ST_IDLE;
            flags_q <= '0;
            fin_q   <= 1'b0;
            cor_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            fin_q   <= fin_d;
            cor_q   <= cor_d;
            res_q   <= res_d;
        end
    end

    assign result         = res_q;
    assign stackOut       = stk_img;
    assign depth          = stk_depth;
    assign stackOverflow  = flags_q.stack_ovf;
    assign dataOverflow   = flags_q.data_ovf;
    assign protocolError  = flags_q.protocol_err;
    assign unexpectedDone = flags_q.unexpected_done;
    assign finished       = fin_q;
    assign correct        = cor_q;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// ---------------------------------------------------------------------------
// tb_rpn_stack_calc
// Bench for rpn_stack_calc: a 16x8 instance checked every cycle against a
// queue-based reference model, plus an 8x4 instance for narrow-width cases.
// ---------------------------------------------------------------------------
module tb_rpn_stack_calc;
    import calc_pkg::*;

    localparam int W   = 16;
    localparam int D   = 8;
    localparam int DW  = $clog2(D + 1);
    localparam int W2  = 8;
    localparam int D2  = 4;
    localparam int DW2 = $clog2(D2 + 1);

    logic clock   = 1'b0;
    logic reset_N = 1'b0;
    always #5 clock = ~clock;

    // ---------------- main instance ----------------
    logic [3:0]               op      = 4'h0;
    logic [W-1:0]             payload = '0;
    logic [W-1:0]             result;
    logic [D-1:0][W-1:0]      stackOut;
    logic [DW-1:0]            depth;
    logic                     stackOverflow, dataOverflow, protocolError;
    logic                     unexpectedDone, finished, correct;

    rpn_stack_calc #(.WIDTH(W), .DEPTH(D)) dut (
        .clock          (clock),
        .reset_N        (reset_N),
        .op             (op),
        .payload        (payload),
        .result         (result),
        .stackOut       (stackOut),
        .depth          (depth),
        .stackOverflow  (stackOverflow),
        .dataOverflow   (dataOverflow),
        .protocolError  (protocolError),
        .unexpectedDone (unexpectedDone),
        .finished       (finished),
        .correct        (correct)
    );

    // ---------------- narrow instance ----------------
    logic [3:0]               op2      = 4'h0;
    logic [W2-1:0]            payload2 = '0;
    logic [W2-1:0]            result2;
    logic [D2-1:0][W2-1:0]    stackOut2;
    logic [DW2-1:0]           depth2;
    logic                     so2, dov2, pe2, ud2, fin2, cor2;

    rpn_stack_calc #(.WIDTH(W2), .DEPTH(D2)) dut2 (
        .clock          (clock),
        .reset_N        (reset_N),
        .op             (op2),
        .payload        (payload2),
        .result         (result2),
        .stackOut       (stackOut2),
        .depth          (depth2),
        .stackOverflow  (so2),
        .dataOverflow   (dov2),
        .protocolError  (pe2),
        .unexpectedDone (ud2),
        .finished       (fin2),
        .correct        (cor2)
    );

    int checks = 0;
    int fails  = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_RUN, M_ERR, M_FIN} mphase_t;

    mphase_t      m_ph  = M_IDLE;
    logic [W-1:0] m_stk[$];
    bit           m_so  = 0, m_dov = 0, m_pe = 0, m_ud = 0;
    bit           m_fin = 0, m_cor = 0;
    logic [W-1:0] m_res = '0;

    task automatic model_reset();
        m_ph = M_IDLE;
        m_stk.delete();
        {m_so, m_dov, m_pe, m_ud, m_fin, m_cor} = '0;
        m_res = '0;
    endtask

    function automatic logic [W-1:0] m_top();
        return (m_stk.size() > 0) ? m_stk[0] : '0;
    endfunction

    task automatic model_step(input logic [3:0] k, input logic [W-1:0] p);
        logic [W:0]   s;
        logic [W-1:0] t;
        int unsigned  c;
        if (k == 4'h0) return;
        if (!(k == 4'h1 || k == 4'h2 || k == 4'h4 || k == 4'h8)) begin
            if (m_ph != M_FIN) begin m_pe = 1; m_ph = M_ERR; end
            return;
        end
        case (m_ph)
            M_IDLE, M_FIN: begin
                if (k == 4'h1) begin
                    {m_so, m_dov, m_pe, m_ud, m_fin, m_cor} = '0;
                    m_res = '0;
                    m_stk.delete();
                    m_stk.push_back(p);
                    m_ph = M_RUN;
                end else if (m_ph == M_IDLE) begin
                    if (k == 4'h8) begin
                        m_ud = 1; m_fin = 1; m_cor = 0; m_ph = M_FIN;
                    end else begin
                        m_pe = 1; m_ph = M_ERR;
                    end
                end
            end
            M_ERR: begin
                if (k == 4'h8) begin
                    m_fin = 1; m_cor = 0; m_res = m_top(); m_ph = M_FIN;
                end
            end
            M_RUN: begin
                if (k == 4'h1) begin
                    m_pe = 1; m_ph = M_ERR;
                end else if (k == 4'h2) begin
                    if (m_stk.size() == D) begin m_so = 1; m_ph = M_ERR; end
                    else m_stk.push_front(p);
                end else if (k == 4'h8) begin
                    m_fin = 1; m_res = m_top(); m_ph = M_FIN;
                    if (m_stk.size() == 1) m_cor = 1;
                    else begin m_cor = 0; m_ud = 1; end
                end else begin
                    c = 32'(p);
                    if (!(c == 1 || c == 2 || c == 4 || c == 8 || c == 16) || m_stk.size() < 2) begin
                        m_pe = 1; m_ph = M_ERR;
                    end else if (c == 8) begin
                        t = m_stk[0]; m_stk[0] = m_stk[1]; m_stk[1] = t;
                    end else if (c == 16) begin
                        m_stk = m_stk[1:$];
                    end else begin
                        // S1 op S0, truncated, replaces both
                        if (c == 1) begin
                            s = {1'b0, m_stk[1]} + {1'b0, m_stk[0]};
                            if (s[W]) begin m_dov = 1; m_ph = M_ERR; end
                            t = s[W-1:0];
                        end else if (c == 2) begin
                            if (m_stk[1] < m_stk[0]) begin m_dov = 1; m_ph = M_ERR; end
                            t = m_stk[1] - m_stk[0];
                        end else begin
                            t = m_stk[1] & m_stk[0];
                        end
                        m_stk = m_stk[1:$];
                        m_stk[0] = t;
                    end
                end
            end
            default: ;
        endcase
    endtask

    always @(posedge clock or negedge reset_N) begin
        if (!reset_N) model_reset();
        else          model_step(op, payload);
    end

    // ---------------- per-cycle comparison ----------------
    task automatic compare_all();
        check("depth", 64'(depth), 64'(m_stk.size()));
        for (int i = 0; i < D; i++) begin
            check($sformatf("stackOut[%0d]", i), 64'(stackOut[i]),
                  (i < m_stk.size()) ? 64'(m_stk[i]) : 64'd0);
        end
        check("stackOverflow",  64'(stackOverflow),  64'(m_so));
        check("dataOverflow",   64'(dataOverflow),   64'(m_dov));
        check("protocolError",  64'(protocolError),  64'(m_pe));
        check("unexpectedDone", 64'(unexpectedDone), 64'(m_ud));
        check("finished",       64'(finished),       64'(m_fin));
        check("correct",        64'(correct),        64'(m_cor));
        if (m_fin) check("result", 64'(result), 64'(m_res));
    endtask

    always @(negedge clock) begin
        if (check_en && reset_N) compare_all();
    end

    // ---------------- stimulus helpers ----------------
    task automatic key(input logic [3:0] k, input logic [W-1:0] p);
        @(negedge clock);
        op = k; payload = p;
        @(posedge clock);
        #1;
        op = 4'h0; payload = '0;
    endtask

    task automatic key2(input logic [3:0] k, input logic [W2-1:0] p);
        @(negedge clock);
        op2 = k; payload2 = p;
        @(posedge clock);
        #1;
        op2 = 4'h0; payload2 = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        #2 reset_N = 1'b0;
        @(negedge clock);
        reset_N = 1'b1;
    endtask

    task automatic check_flags(input string tag, input bit so, input bit dov,
                               input bit pe, input bit ud);
        check({tag, ".stackOverflow"},  64'(stackOverflow),  64'(so));
        check({tag, ".dataOverflow"},   64'(dataOverflow),   64'(dov));
        check({tag, ".protocolError"},  64'(protocolError),  64'(pe));
        check({tag, ".unexpectedDone"}, 64'(unexpectedDone), 64'(ud));
    endtask

    // Non-one-hot, non-zero key values.
    logic [3:0] bad_keys [11] = '{4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA,
                                  4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    int unsigned codes [5] = '{1, 2, 4, 8, 16};

    initial begin
        // Reset state
        #1;
        check("rst.depth", 64'(depth), 64'd0);
        check("rst.stackOut0", 64'(stackOut[0]), 64'd0);
        check("rst.finished", 64'(finished), 64'd0);
        check("rst.correct", 64'(correct), 64'd0);
        check("rst.result", 64'(result), 64'd0);
        check_flags("rst", 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_N  = 1'b1;
        check_en = 1'b1;

        // 5 + 3 = 8
        key(4'h1, 16'd5); key(4'h2, 16'd3); key(4'h4, 16'd1); key(4'h8, 16'd0);
        check("add.result", 64'(result), 64'd8);
        check("add.finished", 64'(finished), 64'd1);
        check("add.correct", 64'(correct), 64'd1);
        check_flags("add", 0, 0, 0, 0);

        // fill to DEPTH then one more ENTER
        key(4'h1, 16'd1);
        for (int v = 2; v <= 8; v++) key(4'h2, 16'(v));
        check("full.depth", 64'(depth), 64'd8);
        key(4'h2, 16'd9);
        check("ovf.stackOverflow", 64'(stackOverflow), 64'd1);
        check("ovf.stackOut0", 64'(stackOut[0]), 64'd8);
        check("ovf.stackOut7", 64'(stackOut[7]), 64'd1);
        check("ovf.depth", 64'(depth), 64'd8);
        key(4'h8, 16'd0);
        check("ovf.finished", 64'(finished), 64'd1);
        check("ovf.correct", 64'(correct), 64'd0);

        // 2 - 5 borrows
        key(4'h1, 16'd2); key(4'h2, 16'd5); key(4'h4, 16'd2);
        check("sub.dataOverflow", 64'(dataOverflow), 64'd1);
        check("sub.stackOut0", 64'(stackOut[0]), 64'hFFFD);
        check("sub.depth", 64'(depth), 64'd1);
        key(4'h8, 16'd0);
        check("sub.correct", 64'(correct), 64'd0);
        check("sub.result", 64'(result), 64'hFFFD);

        // SWAP then DROP leaves the first-entered operand's partner
        key(4'h1, 16'd7); key(4'h2, 16'd9); key(4'h4, 16'd8);
        check("swap.stackOut0", 64'(stackOut[0]), 64'd7);
        check("swap.stackOut1", 64'(stackOut[1]), 64'd9);
        key(4'h4, 16'd16); key(4'h8, 16'd0);
        check("drop.result", 64'(result), 64'd9);
        check("drop.correct", 64'(correct), 64'd1);
        key(4'h1, 16'd4);
        check("restart.finished", 64'(finished), 64'd0);
        check("restart.depth", 64'(depth), 64'd1);
        check_flags("restart", 0, 0, 0, 0);

        // AND, then a bad code and DONE from ERR
        key(4'h2, 16'h000C); key(4'h4, 16'd4);
        check("and.stackOut0", 64'(stackOut[0]), 64'd4);
        key(4'h4, 16'd3);
        check("badcode.protocolError", 64'(protocolError), 64'd1);
        key(4'h8, 16'd0);
        check("badcode.result", 64'(result), 64'd4);

        // DONE from IDLE
        pulse_reset();
        key(4'h8, 16'd0);
        check("idledone.unexpectedDone", 64'(unexpectedDone), 64'd1);
        check("idledone.finished", 64'(finished), 64'd1);
        check("idledone.correct", 64'(correct), 64'd0);
        key(4'h1, 16'd1); key(4'h2, 16'd2); key(4'h8, 16'd0);
        check("deepdone.unexpectedDone", 64'(unexpectedDone), 64'd1);
        check("deepdone.correct", 64'(correct), 64'd0);

        // ARITH with one operand, non-one-hot key
        key(4'h1, 16'd1); key(4'h4, 16'd1);
        check("oneop.protocolError", 64'(protocolError), 64'd1);
        check("oneop.depth", 64'(depth), 64'd1);
        key(4'h1, 16'd1); key(4'h3, 16'd0);
        check("nonhot.protocolError", 64'(protocolError), 64'd1);

        // Asynchronous reset mid-transaction
        key(4'h1, 16'd3); key(4'h2, 16'd4);
        @(negedge clock);
        #2 reset_N = 1'b0;
        #1;
        check("arst.depth", 64'(depth), 64'd0);
        check("arst.stackOut0", 64'(stackOut[0]), 64'd0);
        check("arst.stackOut1", 64'(stackOut[1]), 64'd0);
        check("arst.finished", 64'(finished), 64'd0);
        check_flags("arst", 0, 0, 0, 0);
        @(negedge clock);
        reset_N = 1'b1;
        key(4'h8, 16'd0);
        check("arst.unexpectedDone", 64'(unexpectedDone), 64'd1);

        // Narrow instance: 200 + 100 wraps to 44
        key2(4'h1, 8'd200); key2(4'h2, 8'd100); key2(4'h4, 8'd1);
        check("w8.dataOverflow", 64'(dov2), 64'd1);
        check("w8.stackOut0", 64'(stackOut2[0]), 64'd44);
        key2(4'h8, 8'd0);
        check("w8.result", 64'(result2), 64'd44);
        check("w8.finished", 64'(fin2), 64'd1);
        check("w8.correct", 64'(cor2), 64'd0);
        key2(4'h1, 8'd1);
        for (int v = 0; v < 4; v++) key2(4'h2, 8'(v));
        check("w8.stackOverflow", 64'(so2), 64'd1);
        check("w8.depth", 64'(depth2), 64'd4);

        // Randomized traffic on the main instance
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            logic [3:0]  k;
            logic [W-1:0] p;
            r = $urandom_range(0, 99);
            if (r < 8)       k = 4'h0;
            else if (r < 20) k = 4'h1;
            else if (r < 55) k = 4'h2;
            else if (r < 85) k = 4'h4;
            else if (r < 95) k = 4'h8;
            else             k = (m_ph == M_FIN) ? 4'h0 : bad_keys[$urandom_range(0, 10)];
            if (k == 4'h4) begin
                p = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'(codes[$urandom_range(0, 4)]);
            end else begin
                r = $urandom_range(0, 2);
                if (r == 0)      p = W'($urandom_range(0, 15));
                else if (r == 1) p = W'($urandom_range(16'hFFF0, 16'hFFFF));
                else             p = W'($urandom);
            end
            key(k, p);
            if ($urandom_range(0, 299) == 0) pulse_reset();
        end

        @(negedge clock);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
